fifo_write_port: RTL
====================

# fifo_write_port

Write-side controller of the team's single-clock FIFO: the producer-facing end of the same request/handshake protocol the FIFO read controller serves on the consumer side. The block accepts a word from a producer with a level handshake (`write_en` / `ready`) and captures it in a holding register. It then commits the word to the FIFO storage array in one write cycle and advances the write pointer. It derives `full` by comparing its own write pointer against the read pointer supplied by the read side.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of a FIFO word
- `ADDR_WIDTH`, 3, storage address width; depth = 2^ADDR_WIDTH

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `write_en`  in  1  producer request; held high until `ready` is seen
- `data_in`  in  DATA_WIDTH  producer word; sampled only while in HS with `write_en`=1
- `rd_ptr`  in  ADDR_WIDTH+1  read pointer from read side (binary, extra wrap bit)
- `ready`  out  1  handshake acknowledge (HS state)
- `full`  out  1  FIFO holds 2^ADDR_WIDTH words
- `wr_en`  out  1  one-cycle storage write strobe
- `wr_addr`  out  ADDR_WIDTH  storage address, equals `wr_ptr[ADDR_WIDTH-1:0]`
- `wr_data`  out  DATA_WIDTH  holding-register contents
- `wr_ptr`  out  ADDR_WIDTH+1  write pointer to read side (binary, extra wrap bit)

## Operation
- States: Idle, HS, Write (2-bit encoding 0, 1, 2; encoding 3 returns to Idle).
- Idle: go to HS when `write_en`=1 and `full`=0; otherwise stay. In the transition cycle, load `data_in` into the holding register.
- HS: `ready`=1. Each cycle with `write_en`=1, reload the holding register from `data_in` and stay in HS. On the first cycle with `write_en`=0, go to Write. The captured word is the one present on the last cycle `write_en` was high.
- Write: `wr_en`=1. `wr_addr` = current `wr_ptr` low bits. `wr_data` = holding register. At the clock edge ending Write, `wr_ptr` increments modulo 2^(ADDR_WIDTH+1). Next state is Idle unconditionally.
- `ready` and `wr_en` are Moore outputs decoded from the state only.
- `full` is combinational: wrap bits of `wr_ptr` and `rd_ptr` differ and the low ADDR_WIDTH bits are equal.
- Boundary conditions:
  - `full` is evaluated only in Idle. A request while full stays pending with no `ready` until the read side frees a slot.
  - The read side can only lower occupancy, so HS and Write never overflow.
  - Pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 is silent.
  - Reset in HS or Write drops the pending word; no `wr_en` is issued.

## Timing
- Reset values: state Idle; `ready`=0, `wr_en`=0, `wr_ptr`=0, holding register=0.
- `wr_data`=0 and `wr_addr`=0 after reset. `full`=0, given `rd_ptr`=0 from the read side's reset.
- Request in cycle t (not full) gives `ready`=1 from t+1.
- `write_en` dropped in cycle k (first low cycle seen in HS) gives `wr_en`=1 in k+1 and `wr_ptr` incremented at the end of k+1.
- `ready` goes low in cycle k+1. `full` reflects the new pointer from k+2.
- Minimum transaction is 3 cycles (Idle→HS→Write); back-to-back requests restart from Idle.
- `write_en` held high in Idle while not full enters HS each time. The producer must drop `write_en` after `ready` to complete a transfer.

## Structure
- Shared package `fifo_pkg`:
  - state encoding constants (Idle/HS/Write), shared with the read controller
  - default `DATA_WIDTH`/`ADDR_WIDTH` constants
  - the `full` comparison function
- One sub-module, `fifo_ptr_counter`: ADDR_WIDTH+1-bit counter with async active-high reset and increment enable. The read side reuses the same counter.

## Test plan
- Reset mid-HS: `write_en`=1, `data_in`=8'hA5; assert `rst` in HS → `ready`=0, no `wr_en`, `wr_ptr`=0, holding register=0.
- Single write: `rd_ptr`=0; `write_en` high two cycles with `data_in` 8'h11 then 8'h22, then low → one `wr_en` pulse with `wr_addr`=0 and `wr_data`=8'h22; `wr_ptr`=1.
- Fill to full: 8 writes with `rd_ptr`=0 → `wr_ptr`=4'b1000 and `full`=1. A 9th request gives no `ready`. Setting `rd_ptr`=4'b0001 then gives `ready` on the next cycle.
- Wrap: `rd_ptr`=4'b1110, `wr_ptr` at 4'b1111; one write → `wr_addr`=3'd7 and `wr_ptr`=4'b0000; `full`=0.
- Back-to-back: two transactions with minimum spacing → `wr_en` pulses at addresses 0 and 1, with exactly one Idle cycle between Write and the next HS.
- Unused encoding: force state to 2'd3 → Idle on the next clock, with all outputs inactive.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: controller state codes, default
// geometry and the pointer-based full test used by both sides.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 3;

   // Controller states, common to write and read controllers.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HS    = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   // Pointers carry one wrap bit above the address bits.
   // Full: wrap bits differ, address bits equal.
   function automatic logic ptr_full(
      input logic [31:0] wp,
      input logic [31:0] rp,
      input int          aw
   );
      logic [31:0] diff;
      logic [31:0] lo_mask;
      logic [31:0] wrap_bit;
      diff     = wp ^ rp;
      wrap_bit = 32'd1 << aw;
      lo_mask  = wrap_bit - 32'd1;
      return ((diff & wrap_bit) != 32'd0) &&
             ((diff & lo_mask) == 32'd0);
   endfunction

endpackage

// File: rtl/fifo_write_port_if.sv
// Producer/storage bundle of the FIFO write controller.
// master: producer + read-side pointer; slave: the controller.
interface fifo_write_port_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);

   logic                  write_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  ready;
   logic                  full;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH:0]   wr_ptr;

   modport master (
      output write_en,
      output data_in,
      output rd_ptr,
      input  ready,
      input  full,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  wr_ptr
   );

   modport slave (
      input  write_en,
      input  data_in,
      input  rd_ptr,
      output ready,
      output full,
      output wr_en,
      output wr_addr,
      output wr_data,
      output wr_ptr
   );

endinterface

// File: rtl/fifo_ptr_counter.sv
// FIFO pointer: binary counter with wrap bit, shared by both sides.
// Ports: clk, rst (async high), inc (enable), count (pointer).
module fifo_ptr_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Wraps silently from all-ones to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fifo_write_port.sv
// FIFO write controller: level handshake capture, one-cycle commit.
// Ports: clk, rst (async high), bus (slave side of the write bundle).
module fifo_write_port
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   fifo_write_port_if.slave   bus
);

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  hold_load;
   logic [DATA_WIDTH-1:0] hold;
   logic [ADDR_WIDTH:0]   ptr;
   logic                  full_w;
   logic                  in_hs;
   logic                  in_write;

   assign in_hs    = (state == ST_HS);
   assign in_write = (state == ST_WRITE);

   assign full_w = ptr_full(32'(ptr), 32'(bus.rd_ptr),
                            ADDR_WIDTH);

   // Full only gates entry from Idle; occupancy cannot grow
   // behind our back once a transfer is under way.
   always_comb begin
      state_nxt = ST_IDLE;
      hold_load = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.write_en && !full_w) begin
               state_nxt = ST_HS;
               hold_load = 1'b1;
            end
         end
         ST_HS: begin
            if (bus.write_en) begin
               state_nxt = ST_HS;
               hold_load = 1'b1;
            end else begin
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Last word seen with write_en high is the one committed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
      end else if (hold_load) begin
         hold <= bus.data_in;
      end
   end

   fifo_ptr_counter #(
      .WIDTH (ADDR_WIDTH + 1)
   ) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc   (in_write),
      .count (ptr)
   );

   assign bus.ready   = in_hs;
   assign bus.wr_en   = in_write;
   assign bus.full    = full_w;
   assign bus.wr_addr = ptr[ADDR_WIDTH-1:0];
   assign bus.wr_data = hold;
   assign bus.wr_ptr  = ptr;

endmodule
